// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direction and target prediction.
// A direct-mapped BTB supplies targets; a gshare PHT indexed by PC XOR global
// history supplies conditional directions. Resolved outcomes from AGEX train
// both structures, and two free-running counters track branches/mispredicts.
module branch_predictor #(
  parameter int DBITS       = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    fe_pc,
  output logic                pred_taken,
  output logic [DBITS-1:0]    pred_target,
  output logic [GHR_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [DBITS-1:0]    upd_pc,
  input  logic [GHR_BITS-1:0] upd_idx,
  input  logic                upd_is_cond,
  input  logic                upd_taken,
  input  logic [DBITS-1:0]    upd_target,
  input  logic                upd_mispred,
  output logic [31:0]         branch_count,
  output logic [31:0]         mispredict_count
);

  localparam int IB       = $clog2(BTB_ENTRIES);
  localparam int TAGW     = DBITS - IB - 2;
  localparam int PHT_SIZE = 1 << GHR_BITS;

  // BTB storage: one entry per index, replaced on every taken resolution
  logic [BTB_ENTRIES-1:0] r_btbValid;
  logic [BTB_ENTRIES-1:0] r_btbIsCond;
  logic [TAGW-1:0]        r_btbTag    [BTB_ENTRIES];
  logic [DBITS-1:0]       r_btbTarget [BTB_ENTRIES];

  // Direction state: 2-bit saturating counters and non-speculative history
  logic [1:0]          r_pht [PHT_SIZE];
  logic [GHR_BITS-1:0] r_ghr;

  logic [31:0] r_branchCount;
  logic [31:0] r_mispredCount;

  logic [IB-1:0]       w_feBtbIdx;
  logic [TAGW-1:0]     w_feTag;
  logic [GHR_BITS-1:0] w_fePhtIdx;
  logic                w_hit;
  logic                w_dirTaken;
  logic                w_predTaken;
  logic [IB-1:0]       w_updBtbIdx;
  logic [TAGW-1:0]     w_updTag;
  logic                w_unusedPcBits;

  // Word-aligned PCs: the two low bits never participate in indexing or tags
  assign w_unusedPcBits = ^{fe_pc[1:0], upd_pc[1:0]};

  assign w_feBtbIdx  = fe_pc[IB+1:2];
  assign w_feTag     = fe_pc[DBITS-1:IB+2];
  assign w_fePhtIdx  = fe_pc[GHR_BITS+1:2] ^ r_ghr;
  assign w_updBtbIdx = upd_pc[IB+1:2];
  assign w_updTag    = upd_pc[DBITS-1:IB+2];

  // Lookup reads only registered state, so a same-cycle update is never bypassed
  always_comb begin
    w_hit       = r_btbValid[w_feBtbIdx] && (r_btbTag[w_feBtbIdx] == w_feTag);
    w_dirTaken  = r_btbIsCond[w_feBtbIdx] ? r_pht[w_fePhtIdx][1] : 1'b1;
    w_predTaken = w_hit && w_dirTaken;
  end

  assign pred_taken       = w_predTaken;
  assign pred_target      = w_predTaken ? r_btbTarget[w_feBtbIdx] : fe_pc + DBITS'(4);
  assign pred_idx         = w_fePhtIdx;
  assign branch_count     = r_branchCount;
  assign mispredict_count = r_mispredCount;

  // BTB install on taken resolutions; not-taken ones leave the entry alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btbValid  <= '0;
      r_btbIsCond <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btbTag[i]    <= '0;
        r_btbTarget[i] <= '0;
      end
    end else if (upd_valid && upd_taken) begin
      r_btbValid[w_updBtbIdx]  <= 1'b1;
      r_btbIsCond[w_updBtbIdx] <= upd_is_cond;
      r_btbTag[w_updBtbIdx]    <= w_updTag;
      r_btbTarget[w_updBtbIdx] <= upd_target;
    end
  end

  // PHT training uses the index captured at fetch, saturating at both ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_SIZE; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (upd_valid && upd_is_cond) begin
      if (upd_taken && (r_pht[upd_idx] != 2'b11)) begin
        r_pht[upd_idx] <= r_pht[upd_idx] + 2'b01;
      end else if (!upd_taken && (r_pht[upd_idx] != 2'b00)) begin
        r_pht[upd_idx] <= r_pht[upd_idx] - 2'b01;
      end
    end
  end

  // Global history shifts only on resolved conditional branches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (upd_valid && upd_is_cond) begin
      r_ghr <= {r_ghr[GHR_BITS-2:0], upd_taken};
    end
  end

  // Debug counters, free-running and wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branchCount  <= '0;
      r_mispredCount <= '0;
    end else if (upd_valid) begin
      r_branchCount <= r_branchCount + 32'd1;
      if (upd_mispred) begin
        r_mispredCount <= r_mispredCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scenarios with a queue-based scoreboard.
// The driver pushes the expected lookup result for each checked cycle; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_branch_predictor;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [7:0]  idx;
    logic        isCond;
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
  } upd_t;

  typedef struct {
    string       name;
    logic        t;
    logic [31:0] tgt;
    logic [7:0]  idx;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fePc = '0;
  logic        predTaken;
  logic [31:0] predTarget;
  logic [7:0]  predIdx;
  logic        updValid = 1'b0;
  logic [31:0] updPc = '0;
  logic [7:0]  updIdx = '0;
  logic        updIsCond = 1'b0;
  logic        updTaken = 1'b0;
  logic [31:0] updTarget = '0;
  logic        updMispred = 1'b0;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;

  branch_predictor #(.DBITS(32), .BTB_ENTRIES(16), .GHR_BITS(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .fe_pc            (fePc),
    .pred_taken       (predTaken),
    .pred_target      (predTarget),
    .pred_idx         (predIdx),
    .upd_valid        (updValid),
    .upd_pc           (updPc),
    .upd_idx          (updIdx),
    .upd_is_cond      (updIsCond),
    .upd_taken        (updTaken),
    .upd_target       (updTarget),
    .upd_mispred      (updMispred),
    .branch_count     (branchCount),
    .mispredict_count (mispredictCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  function automatic upd_t mkUpd(input logic [31:0] pc, input logic [7:0] idx,
                                 input logic isCond, input logic taken,
                                 input logic [31:0] tgt, input logic mis);
    upd_t u;
    u.v = 1'b1; u.pc = pc; u.idx = idx; u.isCond = isCond;
    u.taken = taken; u.tgt = tgt; u.mis = mis;
    return u;
  endfunction

  function automatic upd_t noUpd();
    upd_t u;
    u = '0;
    return u;
  endfunction

  task automatic driveInputs(input logic [31:0] pc, input upd_t u);
    fePc = pc;
    updValid = u.v; updPc = u.pc; updIdx = u.idx; updIsCond = u.isCond;
    updTaken = u.taken; updTarget = u.tgt; updMispred = u.mis;
  endtask

  task automatic pushExp(input string name, input logic t, input logic [31:0] tgt,
                         input logic [7:0] idx, input logic [31:0] bc, input logic [31:0] mc);
    exp_t e;
    e.name = name; e.t = t; e.tgt = tgt; e.idx = idx; e.bc = bc; e.mc = mc;
    expQ.push_back(e);
  endtask

  // One cycle: drive lookup PC and update bundle, optionally record expectation
  task automatic applyStimulus(input logic [31:0] pc, input upd_t u, input bit chk,
                               input string name, input logic t, input logic [31:0] tgt,
                               input logic [7:0] idx, input logic [31:0] bc,
                               input logic [31:0] mc);
    @(posedge clk);
    #1;
    driveInputs(pc, u);
    if (chk) pushExp(name, t, tgt, idx, bc, mc);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    driveInputs(32'h0, noUpd());
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input exp_t e);
    total++;
    if (predTaken !== e.t) begin
      bad++;
      $display("[TB] FAIL %s.taken got=%0h want=%0h", e.name, predTaken, e.t);
    end
    total++;
    if (predTarget !== e.tgt) begin
      bad++;
      $display("[TB] FAIL %s.target got=%0h want=%0h", e.name, predTarget, e.tgt);
    end
    total++;
    if (predIdx !== e.idx) begin
      bad++;
      $display("[TB] FAIL %s.idx got=%0h want=%0h", e.name, predIdx, e.idx);
    end
    total++;
    if (branchCount !== e.bc) begin
      bad++;
      $display("[TB] FAIL %s.bcount got=%0d want=%0d", e.name, branchCount, e.bc);
    end
    total++;
    if (mispredictCount !== e.mc) begin
      bad++;
      $display("[TB] FAIL %s.mcount got=%0d want=%0d", e.name, mispredictCount, e.mc);
    end
  endtask

  // Monitor: outputs are combinational, so every pending expectation is due now
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: run did not complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int waitCyc;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state; upd fields carry junk with upd_valid low and must be ignored
    @(posedge clk);
    #1;
    driveInputs(32'h100, noUpd());
    updPc = 32'h100; updTaken = 1'b1; updTarget = 32'h999; updMispred = 1'b1;
    pushExp("reset", 1'b0, 32'h104, 8'h40, 32'd0, 32'd0);

    // JAL install; same-cycle lookup must still see the old state
    applyStimulus(32'h100, mkUpd(32'h100, 8'h40, 1'b0, 1'b1, 32'h200, 1'b1), 1'b1,
                  "jal_same", 1'b0, 32'h104, 8'h40, 32'd0, 32'd0);
    applyStimulus(32'h100, noUpd(), 1'b1, "jal_hit", 1'b1, 32'h200, 8'h40, 32'd1, 32'd1);
    applyStimulus(32'h140, noUpd(), 1'b1, "tag_miss", 1'b0, 32'h144, 8'h50, 32'd1, 32'd1);

    // Conditional taken at 0x40 replaces BTB index 0 and shifts history to 0x01
    applyStimulus(32'h100, mkUpd(32'h40, 8'h10, 1'b1, 1'b1, 32'h80, 1'b0), 1'b1,
                  "cond_same", 1'b1, 32'h200, 8'h40, 32'd1, 32'd1);
    applyStimulus(32'h40, noUpd(), 1'b1, "cond_weak", 1'b0, 32'h44, 8'h11, 32'd2, 32'd1);
    applyStimulus(32'h100, noUpd(), 1'b1, "replaced", 1'b0, 32'h104, 8'h41, 32'd2, 32'd1);

    // Second taken branch: GHR becomes 0x03, so 0x4C now hashes onto PHT[0x10]=10
    applyStimulus(32'h4C, mkUpd(32'h4C, 8'h12, 1'b1, 1'b1, 32'h300, 1'b1), 1'b1,
                  "gs_same", 1'b0, 32'h50, 8'h12, 32'd2, 32'd1);
    applyStimulus(32'h4C, noUpd(), 1'b1, "gs_taken", 1'b1, 32'h300, 8'h10, 32'd3, 32'd2);

    // Asynchronous reset mid-cycle with a pending update that must be dropped
    @(posedge clk);
    #1;
    driveInputs(32'h4C, mkUpd(32'h80, 8'h20, 1'b0, 1'b1, 32'h700, 1'b1));
    #1;
    reset = 1'b1;
    pushExp("rst_async", 1'b0, 32'h50, 8'h13, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    driveInputs(32'h80, noUpd());
    pushExp("rst_drop", 1'b0, 32'h84, 8'h20, 32'd0, 32'd0);
    applyStimulus(32'h80, mkUpd(32'h80, 8'h20, 1'b0, 1'b1, 32'h600, 1'b0), 1'b1,
                  "post_same", 1'b0, 32'h84, 8'h20, 32'd0, 32'd0);
    applyStimulus(32'h80, noUpd(), 1'b1, "post_hit", 1'b1, 32'h600, 8'h20, 32'd1, 32'd0);

    // Saturation: install 0x14, then drive PHT[0x05] down and PHT[0x0A] up
    doReset();
    applyStimulus(32'h14, mkUpd(32'h14, 8'h99, 1'b1, 1'b1, 32'h400, 1'b1), 1'b1,
                  "sat_reset", 1'b0, 32'h18, 8'h05, 32'd0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h0, mkUpd(32'h14, 8'h05, 1'b1, 1'b0, 32'h0, 1'b0), 1'b0,
                    "", 1'b0, 32'h0, 8'h0, 32'd0, 32'd0);
    end
    applyStimulus(32'h14, noUpd(), 1'b1, "sat_low", 1'b0, 32'h18, 8'h05, 32'd9, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'h0, mkUpd(32'h14, 8'h0A, 1'b1, 1'b1, 32'h500, 1'b1), 1'b0,
                    "", 1'b0, 32'h0, 8'h0, 32'd0, 32'd0);
    end
    applyStimulus(32'h14, noUpd(), 1'b1, "sat_high", 1'b1, 32'h500, 8'h0A, 32'd13, 32'd5);

    // Drain the scoreboard with a bounded wait
    waitCyc = 0;
    while (expQ.size() > 0 && waitCyc < 20) begin
      @(negedge clk);
      #1;
      waitCyc++;
    end
    if (expQ.size() > 0) begin
      bad++;
      $display("[TB] FAIL drain pending=%0d want=0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side branch prediction unit for the five-stage pipeline: a direct-mapped branch target buffer (BTB) plus a gshare pattern history table (PHT) with a global history register (GHR). FE_STAGE presents the fetch PC each cycle and receives a combinational next-PC prediction. AGEX_STAGE sends the resolved outcome of every control-flow instruction back to this unit, carrying it on the AGEX-to-FE path. The unit also keeps branch and mispredict counters for debugging.

## Interface
- DBITS, 32: PC/target width.
- BTB_ENTRIES, 16: BTB depth, power of two; BTB index width IB = log2(BTB_ENTRIES).
- GHR_BITS, 8: GHR width; the PHT has 2^GHR_BITS two-bit counters.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fe_pc  in  DBITS  PC being fetched this cycle.
- pred_taken  out  1  predicted taken.
- pred_target  out  DBITS  predicted next PC.
- pred_idx  out  GHR_BITS  PHT index used for this prediction; travels with the instruction to AGEX.
- upd_valid  in  1  AGEX resolved a control-flow instruction this cycle.
- upd_pc  in  DBITS  PC of the resolved instruction.
- upd_idx  in  GHR_BITS  pred_idx captured when that instruction was fetched.
- upd_is_cond  in  1  1 = conditional branch; 0 = JAL/JALR.
- upd_taken  in  1  resolved direction (always 1 for JAL/JALR).
- upd_target  in  DBITS  resolved target.
- upd_mispred  in  1  AGEX flagged a direction or target mispredict.
- branch_count  out  32  resolved control-flow instructions since reset.
- mispredict_count  out  32  mispredicts since reset.

## Operation
- BTB entry fields: valid, tag = pc[DBITS-1:IB+2], target, is_cond. Index = pc[IB+1:2].
- PHT index = pc[GHR_BITS+1:2] XOR GHR. Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Lookup (combinational from fe_pc and current state):
  - hit = valid && tag match.
  - pred_taken = hit && (is_cond ? PHT[pred_idx][1] : 1).
  - pred_target = pred_taken ? BTB target : fe_pc + 4 (mod 2^DBITS).
  - pred_idx is driven on every cycle, hit or miss.
- Update (rising edge, only when upd_valid=1):
  - BTB: if upd_taken, write the entry at index(upd_pc) with valid=1, tag, upd_target and upd_is_cond, replacing any occupant. Not-taken updates leave the BTB unchanged.
  - PHT: if upd_is_cond, saturating increment of PHT[upd_idx] if taken, decrement if not. Counters stick at 11 and 00.
  - GHR: if upd_is_cond, GHR <= {GHR[GHR_BITS-2:0], upd_taken}. History is non-speculative; JAL/JALR never shift it.
  - branch_count += 1. If upd_mispred, mispredict_count += 1. Both counters wrap modulo 2^32.
- upd_valid=0: no state changes; all upd_* inputs are ignored.

## Timing
- Lookup has zero-cycle latency. An update written at edge N is visible to lookups from cycle N+1 onward.
- Update and lookup in the same cycle, even for the same PC or index: the lookup sees pre-update state; there is no bypass.
- One update per cycle at most; an update takes effect in a single edge.
- Reset state:
  - all BTB valid bits = 0; all PHT counters = 01; GHR = 0; both counters = 0.
  - outputs therefore read pred_taken=0, pred_target=fe_pc+4, pred_idx=fe_pc[GHR_BITS+1:2].
- Reset asserted mid-operation: state clears asynchronously, and an update presented in that cycle is dropped.
- After reset deasserts, the first edge can already perform an update.

## Test plan
- Reset, fe_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_idx=0x40, branch_count=0, mispredict_count=0.
- JAL update (upd_pc=0x100, upd_target=0x200, upd_is_cond=0, upd_taken=1, upd_mispred=1), then fe_pc=0x100 -> pred_taken=1, pred_target=0x200, GHR still 0, branch_count=1, mispredict_count=1.
- Conditional taken update at upd_pc=0x40 with upd_idx=0x10 -> PHT[0x10]=10 and GHR=0x01. A following lookup at fe_pc=0x40 gives pred_idx=0x11; PHT[0x11] is still 01, so pred_taken=0 despite the BTB hit and pred_target=0x44.
- Five not-taken conditional updates at upd_idx=0x05 -> PHT[0x05] goes 01->00 and stays 00; GHR=0x00 after the shifts.
- BTB entry for 0x100 installed, then fe_pc=0x140 (same index 0, different tag) -> pred_taken=0, pred_target=0x144.
- Update and lookup of 0x100 in the same cycle -> that cycle pred_taken=0 and the next cycle 1. Reset pulsed mid-run -> BTB and counters clear immediately and pred_taken=0.
